periph_bus_initiator: RTL and testbench

- Command-driven initiator for the peripheral memory bus, i.e. the requester side of the valid/ready bus that peripheral subsystems such as GPIO respond on.
- Turns single or incrementing-burst read/write commands into bus transactions, one beat at a time.
- Returns one response per beat.
- Enforces a per-beat timeout so that an absent responder cannot hang the requester.
- Used by debug/test masters and the future DMA path alongside the CPU subsystem.

---
 rtl/periph_bus_initiator.sv | 117 +++++++++++
 tb/tb_periph_bus_initiator.sv | 129 ++++++++++++
 2 files changed

// File: rtl/periph_bus_initiator.sv
// periph_bus_initiator: turns single/burst read-write commands into one-beat-at-a-time bus transactions with per-beat timeout
module periph_bus_initiator #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int LEN_W = 4
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [30:0]      cmd_addr,
  input  logic [31:0]      cmd_wdata,
  input  logic [3:0]       cmd_wstrb,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_error,
  output logic             rsp_last,
  output logic             bus_valid,
  output logic [30:0]      bus_addr,
  output logic             bus_write,
  output logic [31:0]      bus_wdata,
  output logic [3:0]       bus_wstrb,
  input  logic [31:0]      bus_rdata,
  input  logic             bus_ready,
  output logic             busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, BUS, RSP} state_t;
  state_t           state_q, state_d;
  logic [30:0]      addr_q, addr_d;
  logic             write_q, write_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [LEN_W-1:0] beats_q, beats_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             error_q, error_d;
  logic             last_q, last_d;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    beats_d = beats_q;
    timer_d = timer_q;
    rdata_d = rdata_q;
    error_d = error_q;
    last_d  = last_q;
    if (state_q == IDLE && cmd_valid) begin
      // read data/strobes are zeroed at latch so the bus sees 0 on reads
      addr_d  = {cmd_addr[30:2], 2'b00};
      write_d = cmd_write;
      wdata_d = cmd_write ? cmd_wdata : 32'd0;
      wstrb_d = cmd_write ? cmd_wstrb : 4'd0;
      beats_d = cmd_len;
      timer_d = '0;
      state_d = BUS;
    end else if (state_q == BUS) begin
      timer_d = timer_q + 1'b1;
      if (bus_ready) begin
        rdata_d = write_q ? 32'd0 : bus_rdata;
        error_d = 1'b0;
        last_d  = (beats_q == '0);
        state_d = RSP;
      end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
        rdata_d = 32'd0;
        error_d = 1'b1;
        last_d  = 1'b1;
        state_d = RSP;
      end
    end else if (state_q == RSP && rsp_ready) begin
      state_d = last_q ? IDLE : BUS;
      addr_d  = last_q ? addr_q : addr_q + 31'd4;
      beats_d = last_q ? beats_q : beats_q - 1'b1;
      timer_d = '0;
    end
  end
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      beats_q <= '0;
      timer_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      beats_q <= beats_d;
      timer_q <= timer_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      last_q  <= last_d;
    end
  end
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign busy      = state_q != IDLE;
  assign bus_valid = state_q == BUS;
  assign rsp_valid = state_q == RSP;
  assign bus_addr  = addr_q;
  assign bus_write = write_q;
  assign bus_wdata = wdata_q;
  assign bus_wstrb = wstrb_q;
  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;
  assign rsp_last  = last_q;
endmodule

// File: tb/tb_periph_bus_initiator.sv
// tb_periph_bus_initiator: randomized bench comparing the initiator against a per-beat transaction model
module tb_periph_bus_initiator;
  localparam int T = 8;
  logic        sys_clk = 0, rst = 1;
  logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [30:0] cmd_addr = 0;
  logic [31:0] cmd_wdata = 0;
  logic [3:0]  cmd_wstrb = 0, cmd_len = 0;
  logic        rsp_valid, rsp_ready = 0, rsp_error, rsp_last;
  logic [31:0] rsp_rdata;
  logic        bus_valid, bus_write, bus_ready = 0, busy;
  logic [30:0] bus_addr;
  logic [31:0] bus_wdata, bus_rdata = 0;
  logic [3:0]  bus_wstrb;
  int total = 0, bad = 0;

  periph_bus_initiator #(.TIMEOUT_CYCLES(T), .LEN_W(4)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_last(rsp_last),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_write(bus_write),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_rdata(bus_rdata),
    .bus_ready(bus_ready), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset();
    check("rst_ctl", 64'({bus_valid, rsp_valid, busy, bus_write, rsp_error, rsp_last, cmd_ready}), 0);
    check("rst_addr", 64'(bus_addr), 0);
    check("rst_wdata", 64'(bus_wdata), 0);
    check("rst_wstrb", 64'(bus_wstrb), 0);
    check("rst_rdata", 64'(rsp_rdata), 0);
  endtask

  // fixd: responder delay (cycles into the beat before ready), <0 random; >=T means never ready
  // bp: response backpressure cycles, <0 random; abort_at: beat index at which rst is pulsed, <0 none
  task automatic run_cmd(input logic w, input logic [30:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input logic [3:0] len,
                         input int fixd, input int bp, input int abort_at);
    logic [31:0] rd;
    logic [30:0] ea;
    logic        last, tmo;
    int d, n, k;
    check("cmd_ready_idle", 64'(cmd_ready), 1);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = wd; cmd_wstrb = ws; cmd_len = len;
    @(negedge sys_clk);
    cmd_valid = 0; cmd_write = 1'($urandom); cmd_addr = 31'($urandom);
    cmd_wdata = $urandom; cmd_wstrb = 4'($urandom); cmd_len = 4'($urandom);
    for (int i = 0; i <= int'(len); i++) begin
      ea = {a[30:2], 2'b00} + 31'(4 * i);
      check("bus_valid_start", 64'(bus_valid), 1);
      if (i == abort_at) begin
        rst = 1; bus_ready = 0;
        @(negedge sys_clk);
        chk_reset();
        rst = 0;
        #1 check("cmd_ready_after_rst", 64'(cmd_ready), 1);
        return;
      end
      d = fixd >= 0 ? fixd : int'($urandom_range(0, T + 1));
      rd = fixd >= 0 ? 32'hDEADBEEF : $urandom;
      n = 0;
      while (bus_valid && n < 40) begin
        check("bus_addr", 64'(bus_addr), 64'(ea));
        check("bus_write", 64'(bus_write), 64'(w));
        check("bus_wdata", 64'(bus_wdata), w ? 64'(wd) : 0);
        check("bus_wstrb", 64'(bus_wstrb), w ? 64'(ws) : 0);
        check("no_overlap_bus", 64'({rsp_valid, cmd_ready, busy}), 1);
        bus_ready = (n == d);
        bus_rdata = (n == d) ? rd : $urandom;
        @(negedge sys_clk);
        n++;
      end
      bus_ready = 0;
      tmo = d >= T;
      check("beat_cycles", 64'(n), tmo ? T : d + 1);
      last = tmo || i == int'(len);
      k = bp >= 0 ? bp : int'($urandom_range(0, 3));
      for (int j = 0; j <= k; j++) begin
        check("rsp_valid", 64'(rsp_valid), 1);
        check("rsp_rdata", 64'(rsp_rdata), (w || tmo) ? 0 : 64'(rd));
        check("rsp_error", 64'(rsp_error), 64'(tmo));
        check("rsp_last", 64'(rsp_last), 64'(last));
        check("no_overlap_rsp", 64'({bus_valid, cmd_ready, busy}), 1);
        rsp_ready = (j == k);
        bus_ready = 1'($urandom);
        @(negedge sys_clk);
      end
      rsp_ready = 0; bus_ready = 0;
      if (last) begin
        check("idle_after_last", 64'({cmd_ready, rsp_valid, bus_valid, busy}), 64'b1000);
        return;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge sys_clk);
    chk_reset();
    rst = 0;
    @(negedge sys_clk);
    run_cmd(0, 31'h103, 0, 0, 0, 2, 0, -1);
    run_cmd(1, 31'h10, 32'hA5A5A5A5, 4'hF, 3, 0, 0, -1);
    run_cmd(0, 31'h40, 0, 0, 1, 0, 5, -1);
    run_cmd(0, 31'h80, 0, 0, 2, T + 5, 0, -1);
    run_cmd(0, 31'h80, 0, 0, 2, T - 1, 0, -1);
    run_cmd(1, 31'h7FFFFFFC, 32'h12345678, 4'h3, 1, 0, 1, -1);
    run_cmd(0, 31'h7FFFFFFE, 0, 0, 1, 1, 0, -1);
    run_cmd(1, 31'h200, 32'h55AA55AA, 4'h5, 3, 1, 0, 1);
    run_cmd(0, 31'h300, 0, 0, 0, 2, 1, -1);
    repeat (40) begin
      repeat ($urandom_range(0, 2)) @(negedge sys_clk);
      run_cmd(1'($urandom), 31'($urandom), $urandom, 4'($urandom), 4'($urandom), -1, -1, -1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
